// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types for the register writeback controller: source tags, the queued
// writeback entry, and the default overflow-queue depth.
package reg_wb_ctrl_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int RD_W          = 5;
    localparam int DATA_W        = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

    typedef struct packed {
        src_e              src;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // x0 is hard-wired, so results aimed at it are dropped on acceptance
    function automatic logic rd_writable(input logic [RD_W-1:0] rd);
        return (rd != 5'd0);
    endfunction

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Dual-push single-pop overflow queue; push0 is the older of two same-cycle pushes.
module wb_fifo
    import reg_wb_ctrl_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push0_i,
    input  wb_entry_t     push0_data_i,
    input  logic          push1_i,
    input  wb_entry_t     push1_data_i,
    input  logic          pop_i,
    output logic          head_valid_o,
    output wb_entry_t     head_o,
    output logic [CW-1:0] count_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_TWO = AW'(2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr0_en_s, wr1_en_s, pop_s;
    logic [AW-1:0] wr1_ptr_s;
    wb_entry_t     wr0_data_s;

    // Next pointers and occupancy; a lone push1 takes the first free slot
    always_comb begin
        pop_s     = pop_i && (count_q != {CW{1'b0}});
        wr0_en_s  = push0_i || push1_i;
        wr1_en_s  = push0_i && push1_i;
        wr1_ptr_s = wr_ptr_q + PTR_ONE;
        if (push0_i) begin
            wr0_data_s = push0_data_i;
        end else begin
            wr0_data_s = push1_data_i;
        end
        if (wr1_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_TWO;
            count_d  = count_q + CNT_TWO;
        end else if (wr0_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_d - CNT_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (wr0_en_s) begin
            mem_q[wr_ptr_q] <= wr0_data_s;
        end
        if (wr1_en_s) begin
            mem_q[wr1_ptr_s] <= push1_data_i;
        end
    end

    assign head_valid_o = (count_q != {CW{1'b0}});
    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file writeback arbiter: merges ALU and load results into one write
// port in acceptance order and tracks registers with loads still in flight.
module reg_wb_ctrl
    import reg_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        reg_we,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic        stall,
    output logic [31:0] pending
);

    localparam int            CW          = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(DEPTH - 1);

    logic          head_valid_s;
    wb_entry_t     head_s;
    logic [CW-1:0] count_s;
    logic          stall_s, accept_s, ld_take_s, alu_take_s;
    wb_entry_t     ld_ent_s, alu_ent_s;
    logic          sel_valid_s, pop_s, push0_s, push1_s;
    wb_entry_t     sel_ent_s, push0_ent_s, push1_ent_s;

    logic          reg_we_q, reg_we_d;
    logic [4:0]    w_addr_q, w_addr_d;
    logic [31:0]   w_data_q, w_data_d;
    logic [31:0]   pending_q, pending_d;

    // Two free slots are kept so a dual push with one pop can never overflow
    assign stall_s    = !rst && (count_s >= STALL_LEVEL);
    assign accept_s   = !rst && !stall_s;
    assign ld_take_s  = accept_s && ld_valid && rd_writable(ld_rd);
    assign alu_take_s = accept_s && alu_valid && rd_writable(alu_rd);
    assign ld_ent_s   = '{src: SRC_LD, rd: ld_rd, data: ld_data};
    assign alu_ent_s  = '{src: SRC_ALU, rd: alu_rd, data: alu_data};

    // Age ordering is queue head, then load, then ALU; losers enqueue in that order
    always_comb begin
        sel_valid_s = 1'b0;
        sel_ent_s   = head_s;
        pop_s       = 1'b0;
        push0_s     = 1'b0;
        push0_ent_s = ld_ent_s;
        push1_s     = 1'b0;
        push1_ent_s = alu_ent_s;
        if (head_valid_s) begin
            sel_valid_s = 1'b1;
            pop_s       = 1'b1;
            push0_s     = ld_take_s;
            push1_s     = alu_take_s;
        end else if (ld_take_s) begin
            sel_valid_s = 1'b1;
            sel_ent_s   = ld_ent_s;
            push0_s     = alu_take_s;
            push0_ent_s = alu_ent_s;
        end else if (alu_take_s) begin
            sel_valid_s = 1'b1;
            sel_ent_s   = alu_ent_s;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (push0_s),
        .push0_data_i (push0_ent_s),
        .push1_i      (push1_s),
        .push1_data_i (push1_ent_s),
        .pop_i        (pop_s),
        .head_valid_o (head_valid_s),
        .head_o       (head_s),
        .count_o      (count_s)
    );

    // Write port next state plus scoreboard; a same-cycle reissue beats the clear
    always_comb begin
        reg_we_d  = sel_valid_s;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        pending_d = pending_q;
        if (sel_valid_s) begin
            w_addr_d = sel_ent_s.rd;
            w_data_d = sel_ent_s.data;
            if (sel_ent_s.src == SRC_LD) begin
                pending_d[sel_ent_s.rd] = 1'b0;
            end else begin
                pending_d = pending_d;
            end
        end else begin
            w_addr_d = w_addr_q;
        end
        if (issue_valid && rd_writable(issue_rd)) begin
            pending_d[issue_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // Output and scoreboard registers
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we_q  <= 1'b0;
            w_addr_q  <= 5'd0;
            w_data_q  <= 32'd0;
            pending_q <= 32'd0;
        end else begin
            reg_we_q  <= reg_we_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            pending_q <= pending_d;
        end
    end

    assign reg_we  = reg_we_q;
    assign w_addr  = w_addr_q;
    assign w_data  = w_data_q;
    assign stall   = stall_s;
    assign pending = pending_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed scenarios plus randomized
// traffic, compared against an in-order queue model of accepted results.
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0, ld_rd = 5'd0, issue_rd = 5'd0;
    logic [31:0] alu_data = 32'd0, ld_data = 32'd0;
    logic        reg_we, stall;
    logic [4:0]  w_addr;
    logic [31:0] w_data, pending;

    always #5 clk = ~clk;

    reg_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .reg_we      (reg_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .stall       (stall),
        .pending     (pending)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: results waiting for the write port, oldest first
    logic [4:0]  m_rd[$];
    logic [31:0] m_data[$];
    bit          m_ld[$];
    bit          exp_we   = 1'b0;
    logic [4:0]  exp_addr = 5'd0;
    logic [31:0] exp_data = 32'd0;
    logic [31:0] exp_pend = 32'd0;
    bit          armed    = 1'b0;
    logic [31:0] rf[32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit model_stall();
        return (m_rd.size() >= DEPTH - 1);
    endfunction

    // One clock: check outputs of the previous edge, drive, check stall, advance model
    task automatic cyc(input bit r,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ldv,
                       input bit av, input logic [4:0] ar, input logic [31:0] adv,
                       input bit iv, input logic [4:0] ir);
        bit es;
        @(negedge clk);
        if (armed) begin
            check("reg_we", 32'(reg_we), 32'(exp_we));
            check("w_addr", 32'(w_addr), 32'(exp_addr));
            check("w_data", w_data, exp_data);
            check("pending", pending, exp_pend);
            if (reg_we) rf[w_addr] = w_data;
        end
        rst = r; ld_valid = lv; ld_rd = lr; ld_data = ldv;
        alu_valid = av; alu_rd = ar; alu_data = adv;
        issue_valid = iv; issue_rd = ir;
        #1;
        es = !r && model_stall();
        if (armed || r) check("stall", 32'(stall), 32'(es));
        if (r) begin
            m_rd.delete(); m_data.delete(); m_ld.delete();
            exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_pend = 32'd0;
            armed = 1'b1;
        end else begin
            if (!es && lv && lr != 5'd0) begin
                m_rd.push_back(lr); m_data.push_back(ldv); m_ld.push_back(1'b1);
            end
            if (!es && av && ar != 5'd0) begin
                m_rd.push_back(ar); m_data.push_back(adv); m_ld.push_back(1'b0);
            end
            if (m_rd.size() > 0) begin
                exp_we   = 1'b1;
                exp_addr = m_rd.pop_front();
                exp_data = m_data.pop_front();
                if (m_ld.pop_front()) exp_pend[exp_addr] = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
            if (iv && ir != 5'd0) exp_pend[ir] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
    endtask

    bit          c_lv, c_av, c_iv;
    logic [4:0]  c_lr, c_ar, c_ir;
    logic [31:0] c_ld, c_ad;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
        idle(2);

        // single ALU result, one-cycle latency
        cyc(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h1234, 0, 5'd0);
        idle(2);

        // collision: load written first, ALU next cycle
        cyc(0, 1, 5'd3, 32'hAAAA, 1, 5'd4, 32'hBBBB, 0, 5'd0);
        idle(3);

        // WAW on x7 resolves to the ALU (younger) value
        cyc(0, 1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0, 5'd0);
        idle(3);
        check("rf7_final", rf[7], 32'h2);

        // back-pressure: both sources always valid, producers hold while stalled
        c_ld = 32'h1000; c_ad = 32'h2000;
        for (int i = 0; i < 16; i++) begin
            if (!model_stall()) begin
                c_ld = c_ld + 32'd1; c_ad = c_ad + 32'd1;
                c_lr = 5'($urandom_range(31, 1)); c_ar = 5'($urandom_range(31, 1));
            end
            cyc(0, 1, c_lr, c_ld, 1, c_ar, c_ad, 0, 5'd0);
        end
        idle(5);

        // scoreboard set, clear on load writeback, set-wins on same-cycle reissue
        cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
        idle(1);
        cyc(0, 1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 0, 5'd0);
        idle(1);
        cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
        cyc(0, 1, 5'd9, 32'h98, 0, 5'd0, 32'd0, 1, 5'd9);
        idle(2);
        cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0);
        idle(1);

        // reset with entries queued, inputs active during reset
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 5'(10 + i), 32'(i + 32'h50), 1, 5'(20 + i), 32'(i + 32'h60), 1, 5'(11 + i));
        cyc(1, 1, 5'd12, 32'h77, 1, 5'd13, 32'h78, 1, 5'd14);
        idle(3);
        cyc(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 0, 5'd0);
        idle(2);

        // randomized traffic with held inputs under stall and occasional reset
        c_lv = 0; c_av = 0; c_lr = 5'd0; c_ar = 5'd0; c_ld = 32'd0; c_ad = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!model_stall()) begin
                c_lv = 1'($urandom_range(1, 0)); c_av = 1'($urandom_range(1, 0));
                c_lr = 5'($urandom_range(31, 0)); c_ar = 5'($urandom_range(31, 0));
                c_ld = $urandom; c_ad = $urandom;
            end
            c_iv = ($urandom_range(3, 0) == 0);
            c_ir = 5'($urandom_range(31, 0));
            cyc(($urandom_range(63, 0) == 0), c_lv, c_lr, c_ld, c_av, c_ar, c_ad, c_iv, c_ir);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, overflow FIFO entry count (power of two, >=4).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: alu_valid  in  1  ALU result present; alu_rd  in  5  dest reg; alu_data  in  32  result.
REQ-004 SHALL have ports: ld_valid  in  1  load data returned; ld_rd  in  5  dest reg; ld_data  in  32  load data.
REQ-005 SHALL have ports: issue_valid  in  1  load issued; issue_rd  in  5  its dest reg.
REQ-006 SHALL have ports: reg_we  out  1  register-file write enable; w_addr  out  5  write address; w_data  out  32  write data.
REQ-007 SHALL have ports: stall  out  1  producers hold inputs; pending  out  32  per-register outstanding-load bitmap.
REQ-008 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-009 SHALL register reg_we/w_addr/w_data; at most one write per cycle.
REQ-010 SHALL accept inputs only in cycles where stall=0; inputs presented with stall=1 are ignored and must be held by producers.
REQ-011 SHALL discard accepted results with rd=0 (no enqueue, no reg_we), so x0 is never written.
REQ-012 SHALL order same-cycle inputs as ld older than alu.
REQ-013 SHALL each cycle select the oldest candidate among {FIFO head, ld, alu} for writeback next cycle; remaining candidates enqueue in age order.
REQ-014 SHALL give latency 1: result accepted in cycle N with empty FIFO -> reg_we=1 in cycle N+1.
REQ-015 SHALL preserve acceptance order at the write port, so WAW to the same rd resolves to the younger value.
REQ-016 SHALL drive stall combinationally as (FIFO count >= DEPTH-1), guaranteeing no overflow with two pushes and one pop.
REQ-017 SHALL drive reg_we=0, holding w_addr/w_data, in cycles with no candidate.
REQ-018 SHALL set pending[issue_rd] on issue_valid (issue_rd != 0), independent of stall.
REQ-019 SHALL clear pending[rd] in the cycle a ld-sourced entry for rd is written (reg_we=1).
REQ-020 SHALL let set win over clear when the same rd is set and cleared in one cycle.
REQ-021 SHALL hold pending[0]=0 permanently.
REQ-022 SHALL tag each FIFO entry with source (ld/alu) to support REQ-019.

Reset
REQ-023 SHALL on rst=1 clear FIFO count and pointers, reg_we=0, w_addr=0, w_data=0, pending=0, in the next cycle.
REQ-024 SHALL drop all queued entries when reset occurs mid-operation; no write occurs in the cycle after reset.
REQ-025 SHALL ignore all inputs while rst=1; stall=0 during reset.

Structure
REQ-026 SHALL keep source-tag encodings and DEPTH default in define.vh.
REQ-027 SHALL instantiate one sub-module, wb_fifo (dual-push single-pop FIFO); scoreboard and selection logic live in the top.

Verification
REQ-028 Single ALU: alu_valid, rd=5, data=0x1234 in cycle 0 -> reg_we=1, w_addr=5, w_data=0x1234 in cycle 1.
REQ-029 Collision: ld rd=3 0xAAAA and alu rd=4 0xBBBB same cycle -> rd3 write cycle 1, rd4 write cycle 2.
REQ-030 WAW: ld rd=7 0x1 and alu rd=7 0x2 same cycle -> writes 0x1 then 0x2; final reg7=0x2.
REQ-031 Back-pressure: both sources valid every cycle -> stall rises at count 3, no entry lost, write order equals acceptance order.
REQ-032 Scoreboard: issue rd=9 -> pending[9]=1 next cycle; ld rd=9 written -> pending[9]=0; same-cycle reissue rd=9 keeps it 1.
REQ-033 Reset: rst pulsed with 3 entries queued -> reg_we=0, pending=0, stall=0 after; rd=0 input never writes.
